axis_consumer_buf: RTL
======================

Name: axis_consumer_buf

Overview:
Parametrised successor to the single-register valid/ready data consumer. It is a stream sink with a DEPTH-entry first-word-fall-through buffer, a programmable ready-throttle for backpressure testing, packet framing on s_last, beat/packet counters, a per-packet XOR checksum and a sticky handshake-protocol checker. It sits at the end of a valid/ready stream in the proof-of-concept stream fabric. Downstream logic or a testbench drains it through a pop interface.

Parameters:
DATA_W, 32, width of s_data/out_data
DEPTH, 8, buffer entries; power of 2, >= 2
CNT_W, 16, width of beat_cnt and pkt_cnt

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
s_vld  in  1  upstream data valid
s_rdy  out  1  sink ready
s_data  in  DATA_W  upstream data
s_last  in  1  last beat of packet
thr_period  in  4  throttle period; 0 = no throttle
pop  in  1  consume head entry
out_vld  out  1  buffer non-empty
out_data  out  DATA_W  head entry data
out_last  out  1  head entry last flag
level  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
stat_clr  in  1  synchronous clear of statistics
beat_cnt  out  CNT_W  accepted beats
pkt_cnt  out  CNT_W  accepted packets (s_last beats)
pkt_csum  out  DATA_W  XOR of all beats of the last completed packet
csum_vld  out  1  1-cycle pulse after pkt_csum update
proto_err  out  1  sticky protocol violation flag

Behaviour:
- Reset (rst_n low, asynchronous): pointers, level, thr_cnt, csum_acc, beat_cnt, pkt_cnt, pkt_csum cleared to 0. csum_vld, proto_err, out_vld cleared to 0. s_rdy is 0 while rst_n is low. Buffer contents are don't-care. Reset mid-packet discards all state, including any partial checksum.
- Throttle: 4-bit thr_cnt register. thr_stall = (thr_period != 0) && (thr_cnt == thr_period).
  - thr_period == 0: thr_cnt holds 0.
  - Otherwise thr_cnt increments every cycle and returns to 0 on the cycle after thr_stall.
  - Result: one stall cycle every thr_period+1 cycles.
- Ready and accept:
  - s_rdy = !full && !thr_stall, where full = (level == DEPTH). Decoded from registers only; no combinational path from pop or s_vld.
  - accept = s_vld && s_rdy. On accept, {s_last, s_data} is written at the write pointer.
- Drain:
  - out_vld = (level != 0). out_data/out_last show the head entry combinationally (FWFT).
  - pop with out_vld=1 advances the read pointer. pop with level==0 is ignored.
- Occupancy:
  - Accept and pop in the same cycle: level unchanged, both pointers advance.
  - When full, pop does not raise s_rdy until the next cycle (no pass-through).
  - Pointers wrap modulo DEPTH.
- Latency: an accepted beat is visible on out_data the cycle after accept.
- Statistics (per accept):
  - beat_cnt += 1, wrapping at 2^CNT_W.
  - Without s_last: csum_acc ^= s_data.
  - With s_last: pkt_csum <= csum_acc ^ s_data, csum_acc <= 0, pkt_cnt += 1 (wraps), csum_vld = 1 the next cycle only. A single-beat packet gives pkt_csum = s_data.
- stat_clr: clears beat_cnt, pkt_cnt, csum_acc, pkt_csum, csum_vld and proto_err next cycle. It has priority over a same-cycle accept: the beat enters the buffer but is not counted or checksummed. The buffer is unaffected.
- Protocol checker: capture prev = s_vld && !s_rdy plus s_data/s_last each cycle. If prev was set and this cycle has s_vld==0 or changed s_data/s_last, proto_err is set and held until stat_clr or reset. The checker does not affect data flow.

Test Plan:
- Reset/idle: rst_n low then high, thr_period=0 -> s_rdy=1, out_vld=0, level=0, all counters 0, proto_err=0.
- Fill/full: DEPTH=8, pop=0, stream 0x00000001..0x0000000A with s_vld held -> 8 accepted, s_rdy=0 when level=8. Then pop every cycle -> out_data 1..8 in order, then 9 and 0xA accepted; no loss or duplication.
- Simultaneous push/pop at level=3 -> level stays 3 across 5 cycles and order is preserved. Pop at level=0 -> level stays 0.
- Throttle: thr_period=3, s_vld always 1, pop always 1 -> s_rdy low exactly 1 cycle in every 4; 12 cycles give 9 accepts.
- Checksum: packet 0x11110000, 0x00002222, 0x0F0F0F0F (last) -> pkt_csum=0x1E1E2D2D, csum_vld pulse 1 cycle, pkt_cnt=1, beat_cnt=3. Next single-beat packet 0xDEADBEEF -> pkt_csum=0xDEADBEEF.
- Protocol/clear: with s_rdy=0 (full), change s_data while s_vld=1 -> proto_err=1 and sticky. stat_clr -> proto_err=0, beat_cnt=0, level unchanged. Assert rst_n low mid-packet -> csum_acc lost, next packet checksum starts from 0.

Source files
------------

// File: rtl/axis_consumer_buf.sv
// Valid/ready stream sink: DEPTH-entry FWFT buffer drained by pop, with ready throttle,
// beat/packet counters, per-packet XOR checksum and a sticky handshake checker.
module axis_consumer_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_vld,
  output logic                       s_rdy,
  input  logic [DATA_W-1:0]          s_data,
  input  logic                       s_last,
  input  logic [3:0]                 thr_period,
  input  logic                       pop,
  output logic                       out_vld,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       stat_clr,
  output logic [CNT_W-1:0]           beat_cnt,
  output logic [CNT_W-1:0]           pkt_cnt,
  output logic [DATA_W-1:0]          pkt_csum,
  output logic                       csum_vld,
  output logic                       proto_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W:0]     mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [3:0]          thr_cnt_q, thr_cnt_d;
  logic [DATA_W-1:0]   csum_acc_q, csum_acc_d, pkt_csum_q, pkt_csum_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic                csum_vld_q, csum_vld_d, proto_err_q, proto_err_d;
  logic                prev_q, prev_d, prev_last_q, prev_last_d;
  logic [DATA_W-1:0]   prev_data_q, prev_data_d;

  logic full, thr_stall, accept, do_pop, violation;

  assign full      = (level_q == LW'(DEPTH));
  assign thr_stall = (thr_period != 4'd0) && (thr_cnt_q == thr_period);
  // Ready depends on registered state only, so a pop never opens the sink in the same cycle.
  assign s_rdy     = rst_n && !full && !thr_stall;
  assign accept    = s_vld && s_rdy;
  assign do_pop    = pop && (level_q != '0);
  assign violation = prev_q && (!s_vld || (s_data != prev_data_q) || (s_last != prev_last_q));

  assign out_vld   = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q][DATA_W-1:0];
  assign out_last  = mem_q[rd_ptr_q][DATA_W];
  assign level     = level_q;
  assign beat_cnt  = beat_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign pkt_csum  = pkt_csum_q;
  assign csum_vld  = csum_vld_q;
  assign proto_err = proto_err_q;

  always_comb begin
    wr_ptr_d    = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d     = level_q;
    if (accept && !do_pop) level_d = level_q + LW'(1);
    else if (!accept && do_pop) level_d = level_q - LW'(1);

    thr_cnt_d = '0;
    if (thr_period != 4'd0 && !thr_stall) thr_cnt_d = thr_cnt_q + 4'd1;

    prev_d      = s_vld && !s_rdy;
    prev_data_d = s_data;
    prev_last_d = s_last;

    beat_cnt_d  = beat_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    csum_acc_d  = csum_acc_q;
    pkt_csum_d  = pkt_csum_q;
    csum_vld_d  = 1'b0;
    proto_err_d = proto_err_q || violation;
    // Clear wins over a same-cycle accept: the beat is buffered but not counted.
    if (stat_clr) begin
      beat_cnt_d  = '0;
      pkt_cnt_d   = '0;
      csum_acc_d  = '0;
      pkt_csum_d  = '0;
      proto_err_d = 1'b0;
    end else if (accept) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
      if (s_last) begin
        pkt_csum_d = csum_acc_q ^ s_data;
        csum_acc_d = '0;
        pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
        csum_vld_d = 1'b1;
      end else begin
        csum_acc_d = csum_acc_q ^ s_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      thr_cnt_q   <= '0;
      csum_acc_q  <= '0;
      pkt_csum_q  <= '0;
      beat_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      csum_vld_q  <= 1'b0;
      proto_err_q <= 1'b0;
      prev_q      <= 1'b0;
      prev_data_q <= '0;
      prev_last_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      thr_cnt_q   <= thr_cnt_d;
      csum_acc_q  <= csum_acc_d;
      pkt_csum_q  <= pkt_csum_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      csum_vld_q  <= csum_vld_d;
      proto_err_q <= proto_err_d;
      prev_q      <= prev_d;
      prev_data_q <= prev_data_d;
      prev_last_q <= prev_last_d;
    end
  end

  // Storage carries no reset; contents are only observed behind out_vld.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {s_last, s_data};
  end
endmodule
